prescaler_ctrl: RTL and testbench

Programmable clock prescaler with run/stop/single-step control, the next generation of the fixed-ratio divider. It derives the CPU clock `clk_out` and an equivalent one-cycle enable `tick` from the board clock. The ratio can be reloaded at runtime without glitches, and the divider can be stopped or single-stepped from a push-button. It sits between the board clock and the TD4 core and debug LEDs.

---
 rtl/prescaler_ctrl_if.sv | 25 ++
 rtl/prescaler_ctrl.sv | 113 +++++++++++
 tb/tb_prescaler_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/prescaler_ctrl_if.sv
// Control and status bundle for the programmable clock prescaler.
// Latency: none, plain wires between controller and prescaler.
// Backpressure: none; div_load is a fire-and-forget strobe, busy reports pending state.
interface prescaler_ctrl_if #(
    parameter int W = 32
);
    logic [1:0]   mode;
    logic         step;
    logic [W-1:0] div_in;
    logic         div_load;
    logic         clk_out;
    logic         tick;
    logic         busy;
    logic [W-1:0] div_cur;

    modport master (
        output mode, step, div_in, div_load,
        input  clk_out, tick, busy, div_cur
    );

    modport slave (
        input  mode, step, div_in, div_load,
        output clk_out, tick, busy, div_cur
    );
endinterface

// File: rtl/prescaler_ctrl.sv
// Programmable clock prescaler with run/stop/single-step control and glitch-free ratio reload.
// Latency: clk_out rises L edges after RUN/STEP entry; ratio applies at the period boundary.
// Backpressure: none; a reload while busy overwrites the pending ratio.
module prescaler_ctrl #(
    parameter int W           = 32,
    parameter int DEFAULT_DIV = 2
) (
    input  logic              clk_in,
    input  logic              rst_n,
    prescaler_ctrl_if.slave   pif
);
    localparam logic [W-1:0] DIV_RST = (DEFAULT_DIV < 2) ? W'(2) : W'(DEFAULT_DIV);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STEP} state_t;

    state_t       state, state_nxt;
    logic [W-1:0] cnt, cnt_nxt;
    logic         clk_out_q, clk_out_nxt;
    logic         tick_q, tick_nxt;
    logic         busy_q;
    logic         apply;
    logic [W-1:0] div_cur_q;
    logic [W-1:0] div_pend;
    logic [W-1:0] div_ld_val;
    logic [W-1:0] half;
    logic         wrap;

    assign half       = div_cur_q >> 1;
    assign wrap       = (cnt == div_cur_q - W'(1));
    assign div_ld_val = (pif.div_in < W'(2)) ? W'(2) : pif.div_in;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Mode is only honoured in IDLE or at a period boundary, which rules out runt pulses.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (pif.mode == 2'b01) begin
                    state_nxt = ST_RUN;
                end else if (pif.mode == 2'b10 && pif.step) begin
                    state_nxt = ST_STEP;
                end
            end
            ST_RUN, ST_STEP: begin
                if (wrap) begin
                    state_nxt = (pif.mode == 2'b01) ? ST_RUN : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_nxt     = '0;
        clk_out_nxt = 1'b0;
        tick_nxt    = 1'b0;
        apply       = 1'b0;
        case (state)
            ST_RUN, ST_STEP: begin
                cnt_nxt     = wrap ? '0 : cnt + W'(1);
                clk_out_nxt = (cnt_nxt >= half);
                tick_nxt    = (cnt_nxt == half);
                apply       = wrap & busy_q;
            end
            default: begin
                apply = busy_q;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            clk_out_q <= clk_out_nxt;
            tick_q    <= tick_nxt;
        end
    end

    // A load coinciding with an apply keeps busy set: the old pending value goes live, the new one waits.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            div_pend  <= DIV_RST;
            div_cur_q <= DIV_RST;
        end else begin
            if (apply) begin
                div_cur_q <= div_pend;
            end
            if (pif.div_load) begin
                div_pend <= div_ld_val;
                busy_q   <= 1'b1;
            end else if (apply) begin
                busy_q   <= 1'b0;
            end
        end
    end

    assign pif.clk_out = clk_out_q;
    assign pif.tick    = tick_q;
    assign pif.busy    = busy_q;
    assign pif.div_cur = div_cur_q;
endmodule

// File: tb/tb_prescaler_ctrl.sv
// Directed bench for prescaler_ctrl: each task drives one scenario and checks hand-computed waveforms.
module tb_prescaler_ctrl;
    logic clk_in;
    logic rst_n;
    int   tests;
    int   fails;

    prescaler_ctrl_if #(.W(32)) pif ();

    prescaler_ctrl #(.W(32), .DEFAULT_DIV(2)) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .pif    (pif)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic edge_step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic apply_reset();
        rst_n        = 1'b0;
        pif.mode     = 2'b00;
        pif.step     = 1'b0;
        pif.div_in   = '0;
        pif.div_load = 1'b0;
        edge_step();
        edge_step();
        rst_n = 1'b1;
    endtask

    task automatic load_idle(input logic [31:0] val);
        pif.div_in   = val;
        pif.div_load = 1'b1;
        edge_step();
        pif.div_load = 1'b0;
        edge_step();
    endtask

    task automatic test_reset();
        logic [4:0] exp_clk;
        exp_clk      = 5'b01010;
        rst_n        = 1'b0;
        pif.mode     = 2'b01;
        pif.step     = 1'b0;
        pif.div_in   = '0;
        pif.div_load = 1'b0;
        edge_step();
        tests++; if (pif.clk_out !== 1'b0) begin fails++; $display("FAIL reset_clk_out got %b exp 0", pif.clk_out); end
        tests++; if (pif.tick !== 1'b0) begin fails++; $display("FAIL reset_tick got %b exp 0", pif.tick); end
        tests++; if (pif.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", pif.busy); end
        tests++; if (pif.div_cur !== 32'd2) begin fails++; $display("FAIL reset_div_cur got %0d exp 2", pif.div_cur); end
        rst_n = 1'b1;
        for (int j = 0; j < 5; j++) begin
            edge_step();
            tests++; if (pif.clk_out !== exp_clk[j]) begin fails++; $display("FAIL n2_clk_out j=%0d got %b exp %b", j, pif.clk_out, exp_clk[j]); end
            tests++; if (pif.tick !== exp_clk[j]) begin fails++; $display("FAIL n2_tick j=%0d got %b exp %b", j, pif.tick, exp_clk[j]); end
        end
    endtask

    task automatic test_load_idle();
        logic [9:0] exp_clk;
        logic [9:0] exp_tick;
        exp_clk  = 10'b1110011100;
        exp_tick = 10'b0010000100;
        apply_reset();
        pif.div_in   = 32'd5;
        pif.div_load = 1'b1;
        edge_step();
        pif.div_load = 1'b0;
        tests++; if (pif.busy !== 1'b1) begin fails++; $display("FAIL idle_load_busy got %b exp 1", pif.busy); end
        tests++; if (pif.div_cur !== 32'd2) begin fails++; $display("FAIL idle_load_old_div got %0d exp 2", pif.div_cur); end
        edge_step();
        tests++; if (pif.busy !== 1'b0) begin fails++; $display("FAIL idle_apply_busy got %b exp 0", pif.busy); end
        tests++; if (pif.div_cur !== 32'd5) begin fails++; $display("FAIL idle_apply_div got %0d exp 5", pif.div_cur); end
        pif.mode = 2'b01;
        for (int j = 0; j < 10; j++) begin
            edge_step();
            tests++; if (pif.clk_out !== exp_clk[j]) begin fails++; $display("FAIL n5_clk_out j=%0d got %b exp %b", j, pif.clk_out, exp_clk[j]); end
            tests++; if (pif.tick !== exp_tick[j]) begin fails++; $display("FAIL n5_tick j=%0d got %b exp %b", j, pif.tick, exp_tick[j]); end
        end
    endtask

    task automatic test_reload_run();
        logic [14:0] exp_clk;
        logic [14:0] exp_tick;
        logic [14:0] exp_busy;
        logic [31:0] exp_div;
        exp_clk  = 15'b011011011110000;
        exp_tick = 15'b001001000010000;
        exp_busy = 15'b000000011111000;
        apply_reset();
        load_idle(32'd8);
        pif.mode = 2'b01;
        for (int j = 0; j < 15; j++) begin
            edge_step();
            pif.div_in   = 32'd3;
            pif.div_load = (j == 2);
            exp_div      = (j < 8) ? 32'd8 : 32'd3;
            tests++; if (pif.clk_out !== exp_clk[j]) begin fails++; $display("FAIL reload_clk_out j=%0d got %b exp %b", j, pif.clk_out, exp_clk[j]); end
            tests++; if (pif.tick !== exp_tick[j]) begin fails++; $display("FAIL reload_tick j=%0d got %b exp %b", j, pif.tick, exp_tick[j]); end
            tests++; if (pif.busy !== exp_busy[j]) begin fails++; $display("FAIL reload_busy j=%0d got %b exp %b", j, pif.busy, exp_busy[j]); end
            tests++; if (pif.div_cur !== exp_div) begin fails++; $display("FAIL reload_div_cur j=%0d got %0d exp %0d", j, pif.div_cur, exp_div); end
        end
    endtask

    task automatic test_load_small();
        apply_reset();
        load_idle(32'd7);
        tests++; if (pif.div_cur !== 32'd7) begin fails++; $display("FAIL small_pre_div got %0d exp 7", pif.div_cur); end
        load_idle(32'd0);
        tests++; if (pif.div_cur !== 32'd2) begin fails++; $display("FAIL small_load0 got %0d exp 2", pif.div_cur); end
        load_idle(32'd9);
        load_idle(32'd1);
        tests++; if (pif.div_cur !== 32'd2) begin fails++; $display("FAIL small_load1 got %0d exp 2", pif.div_cur); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        pif.div_in   = 32'd9;
        pif.div_load = 1'b1;
        edge_step();
        pif.div_in   = 32'd1;
        edge_step();
        pif.div_load = 1'b0;
        tests++; if (pif.div_cur !== 32'd9) begin fails++; $display("FAIL b2b_first_div got %0d exp 9", pif.div_cur); end
        tests++; if (pif.busy !== 1'b1) begin fails++; $display("FAIL b2b_busy_held got %b exp 1", pif.busy); end
        edge_step();
        tests++; if (pif.div_cur !== 32'd2) begin fails++; $display("FAIL b2b_second_div got %0d exp 2", pif.div_cur); end
        tests++; if (pif.busy !== 1'b0) begin fails++; $display("FAIL b2b_busy_clear got %b exp 0", pif.busy); end
    endtask

    task automatic test_step();
        logic [7:0] exp_clk;
        logic [7:0] exp_tick;
        exp_clk  = 8'b00001100;
        exp_tick = 8'b00000100;
        apply_reset();
        load_idle(32'd4);
        pif.mode = 2'b10;
        pif.step = 1'b1;
        for (int j = 0; j < 8; j++) begin
            edge_step();
            pif.step = (j == 0);
            tests++; if (pif.clk_out !== exp_clk[j]) begin fails++; $display("FAIL step1_clk_out j=%0d got %b exp %b", j, pif.clk_out, exp_clk[j]); end
            tests++; if (pif.tick !== exp_tick[j]) begin fails++; $display("FAIL step1_tick j=%0d got %b exp %b", j, pif.tick, exp_tick[j]); end
        end
        pif.step = 1'b1;
        for (int j = 0; j < 7; j++) begin
            edge_step();
            pif.step = 1'b0;
            tests++; if (pif.clk_out !== exp_clk[j]) begin fails++; $display("FAIL step2_clk_out j=%0d got %b exp %b", j, pif.clk_out, exp_clk[j]); end
            tests++; if (pif.tick !== exp_tick[j]) begin fails++; $display("FAIL step2_tick j=%0d got %b exp %b", j, pif.tick, exp_tick[j]); end
        end
    endtask

    task automatic test_stop();
        logic [9:0] exp_clk;
        logic [9:0] exp_tick;
        exp_clk  = 10'b0000111000;
        exp_tick = 10'b0000001000;
        apply_reset();
        load_idle(32'd6);
        pif.mode = 2'b01;
        for (int j = 0; j < 10; j++) begin
            edge_step();
            if (j == 3) pif.mode = 2'b00;
            tests++; if (pif.clk_out !== exp_clk[j]) begin fails++; $display("FAIL stop_clk_out j=%0d got %b exp %b", j, pif.clk_out, exp_clk[j]); end
            tests++; if (pif.tick !== exp_tick[j]) begin fails++; $display("FAIL stop_tick j=%0d got %b exp %b", j, pif.tick, exp_tick[j]); end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        load_idle(32'd6);
        pif.mode = 2'b01;
        for (int j = 0; j < 4; j++) begin
            edge_step();
            pif.div_in   = 32'd5;
            pif.div_load = (j == 2);
        end
        tests++; if (pif.tick !== 1'b1) begin fails++; $display("FAIL mid_pre_tick got %b exp 1", pif.tick); end
        tests++; if (pif.busy !== 1'b1) begin fails++; $display("FAIL mid_pre_busy got %b exp 1", pif.busy); end
        rst_n = 1'b0;
        #1;
        tests++; if (pif.clk_out !== 1'b0) begin fails++; $display("FAIL mid_rst_clk_out got %b exp 0", pif.clk_out); end
        tests++; if (pif.tick !== 1'b0) begin fails++; $display("FAIL mid_rst_tick got %b exp 0", pif.tick); end
        tests++; if (pif.busy !== 1'b0) begin fails++; $display("FAIL mid_rst_busy got %b exp 0", pif.busy); end
        tests++; if (pif.div_cur !== 32'd2) begin fails++; $display("FAIL mid_rst_div_cur got %0d exp 2", pif.div_cur); end
        edge_step();
        rst_n = 1'b1;
        edge_step();
        tests++; if (pif.clk_out !== 1'b0) begin fails++; $display("FAIL mid_restart_low got %b exp 0", pif.clk_out); end
        edge_step();
        tests++; if (pif.clk_out !== 1'b1) begin fails++; $display("FAIL mid_restart_high got %b exp 1", pif.clk_out); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_load_idle();
        test_reload_run();
        test_load_small();
        test_back_to_back();
        test_step();
        test_stop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
